// File: rtl/axis_tx_mac_bridge.sv
// AXI4-Stream slave to legacy MAC transmit user interface.
// Words are buffered in a small FIFO. On the way out the bridge marks the
// start and end of each packet, encodes the byte-enables of the last word,
// and stalls whenever the MAC drops write-allow.
//
// state  | meaning
// IDLE   | FIFO empty, nothing being sent to the MAC
// XFER   | FIFO holds data; one word is popped per cycle while Tx_mac_wa=1
module axis_tx_mac_bridge #(
    parameter int FIFO_AW = 3,
    parameter int CNT_W   = 16
) (
    input  logic             Clk_user,
    input  logic             Reset_n,
    input  logic             S_AXIS_tvalid,
    output logic             S_AXIS_tready,
    input  logic [31:0]      S_AXIS_tdata,
    input  logic [3:0]       S_AXIS_tstrb,
    input  logic             S_AXIS_tlast,
    input  logic             S_AXIS_tdest,
    input  logic             S_AXIS_tid,
    input  logic             Tx_mac_wa,
    output logic             Tx_mac_wr,
    output logic [31:0]      Tx_mac_data,
    output logic [1:0]       Tx_mac_BE,
    output logic             Tx_mac_sop,
    output logic             Tx_mac_eop,
    output logic [CNT_W-1:0] Pkt_cnt,
    output logic [CNT_W-1:0] Strb_err_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // tdest and tid carry no meaning for the MAC
    logic unused_sideband;
    assign unused_sideband = &{1'b0, S_AXIS_tdest, S_AXIS_tid};

    logic [31:0]        mem_data_q [DEPTH];
    logic [3:0]         mem_strb_q [DEPTH];
    logic               mem_last_q [DEPTH];

    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [0:0]         state_q, state_d;
    logic               sop_pending_q, sop_pending_d;
    logic               tready_q, tready_d;
    logic               wr_q, wr_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         be_q, be_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [FIFO_AW:0]   count, count_nxt;
    logic               empty, push, pop, strb_ok;
    logic [3:0]         strb_norm;
    logic [FIFO_AW-1:0] rd_idx, wr_idx;
    logic [31:0]        rd_data;
    logic [3:0]         rd_strb;
    logic               rd_last;
    logic [1:0]         rd_be;

    assign wr_idx  = wr_ptr_q[FIFO_AW-1:0];
    assign rd_idx  = rd_ptr_q[FIFO_AW-1:0];
    assign rd_data = mem_data_q[rd_idx];
    assign rd_strb = mem_strb_q[rd_idx];
    assign rd_last = mem_last_q[rd_idx];

    // Strobe validation: only a last word may be partial, and then only left-aligned
    always_comb begin
        strb_ok = 1'b0;
        if (S_AXIS_tlast) begin
            case (S_AXIS_tstrb)
                4'b1000, 4'b1100, 4'b1110, 4'b1111: strb_ok = 1'b1;
                default:                            strb_ok = 1'b0;
            endcase
        end else begin
            strb_ok = (S_AXIS_tstrb == 4'b1111);
        end
        strb_norm = strb_ok ? S_AXIS_tstrb : 4'b1111;
    end

    // Byte-enable encoding of the entry at the read pointer
    always_comb begin
        case (rd_strb)
            4'b1000: rd_be = 2'b01;
            4'b1100: rd_be = 2'b10;
            4'b1110: rd_be = 2'b11;
            default: rd_be = 2'b00;
        endcase
    end

    // Next-state logic for FIFO pointers, output FSM, MAC outputs and counters.
    // The first pop may share the cycle in which IDLE is left, which keeps the
    // accept-to-write latency at two cycles.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        count     = wr_ptr_q - rd_ptr_q;
        push      = S_AXIS_tvalid & tready_q;
        pop       = ~empty & Tx_mac_wa;
        count_nxt = count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        tready_d  = (count_nxt < (FIFO_AW+1)'(DEPTH - 1));

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty)         state_d = ST_XFER;
            ST_XFER: if (empty && !pop)  state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase

        wr_d          = pop;
        data_d        = pop ? rd_data : data_q;
        sop_d         = pop & sop_pending_q;
        eop_d         = pop & rd_last;
        be_d          = (pop & rd_last) ? rd_be : 2'b00;
        sop_pending_d = pop ? rd_last : sop_pending_q;

        pkt_cnt_d = pkt_cnt_q + CNT_W'(wr_q & eop_q);
        err_cnt_d = err_cnt_q + CNT_W'(push & ~strb_ok);
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge Clk_user) begin
        if (push) begin
            mem_data_q[wr_idx] <= S_AXIS_tdata;
            mem_strb_q[wr_idx] <= strb_norm;
            mem_last_q[wr_idx] <= S_AXIS_tlast;
        end
    end

    // Control, output and counter registers
    always_ff @(posedge Clk_user or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= ST_IDLE;
            sop_pending_q <= 1'b1;
            tready_q      <= 1'b0;
            wr_q          <= 1'b0;
            data_q        <= '0;
            be_q          <= '0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
            pkt_cnt_q     <= '0;
            err_cnt_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            sop_pending_q <= sop_pending_d;
            tready_q      <= tready_d;
            wr_q          <= wr_d;
            data_q        <= data_d;
            be_q          <= be_d;
            sop_q         <= sop_d;
            eop_q         <= eop_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign S_AXIS_tready = tready_q;
    assign Tx_mac_wr     = wr_q;
    assign Tx_mac_data   = data_q;
    assign Tx_mac_BE     = be_q;
    assign Tx_mac_sop    = sop_q;
    assign Tx_mac_eop    = eop_q;
    assign Pkt_cnt       = pkt_cnt_q;
    assign Strb_err_cnt  = err_cnt_q;

endmodule
